// File: rtl/score_display_pkg.sv
// Shared types and helpers for the score display: conversion FSM states and
// active-low 7-segment encoding.
package score_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONV_P1,
    CONV_P2,
    COMMIT
  } cvt_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order is {g,f,e,d,c,b,a}, active-low; non-decimal codes go dark.
  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    logic [6:0] segs;
    case (digit)
      4'd0:    segs = 7'h40;
      4'd1:    segs = 7'h79;
      4'd2:    segs = 7'h24;
      4'd3:    segs = 7'h30;
      4'd4:    segs = 7'h19;
      4'd5:    segs = 7'h12;
      4'd6:    segs = 7'h02;
      4'd7:    segs = 7'h78;
      4'd8:    segs = 7'h00;
      4'd9:    segs = 7'h10;
      default: segs = SEG_BLANK;
    endcase
    return segs;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Iterative 8-bit binary to 3-digit BCD converter (double-dabble). One start pulse,
// eight shift cycles, then a one-cycle done pulse with bcd valid until the next start.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  bin,
  output logic        done,
  output logic [11:0] bcd
);

  logic [11:0] r_bcd;
  logic [7:0]  r_shift;
  logic [2:0]  r_count;
  logic        r_active;
  logic        r_done;
  logic [11:0] w_adjusted;

  always_comb begin
    w_adjusted = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_adjusted[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  // A start always wins, so a new conversion may begin in the same cycle done is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bcd    <= '0;
      r_shift  <= '0;
      r_count  <= '0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bcd    <= '0;
        r_shift  <= bin;
        r_count  <= '0;
        r_active <= 1'b1;
      end else if (r_active) begin
        r_bcd   <= {w_adjusted[10:0], r_shift[7]};
        r_shift <= {r_shift[6:0], 1'b0};
        r_count <= r_count + 3'd1;
        if (r_count == 3'd7) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: rtl/score_display.sv
// Converts both player scores to BCD with one shared converter and scans them onto an
// 8-digit multiplexed active-low 7-segment display (P1 on digits 6..4, P2 on 2..0).
module score_display #(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] P1score,
  input  logic [7:0] P2score,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);
  import score_display_pkg::*;

  localparam int            CW           = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(DIGIT_CYCLES - 1);

  cvt_state_t    r_state, w_nextState;
  logic [15:0]   r_lastSrc, r_snap;
  logic          r_startP1;
  logic [11:0]   r_stageP1, r_stageP2, r_dispP1, r_dispP2;
  logic          w_change, w_cvtStart, w_cvtDone;
  logic [7:0]    w_cvtBin;
  logic [11:0]   w_cvtBcd;
  logic [CW-1:0] r_refresh;
  logic [2:0]    r_digitIdx;
  logic [7:0]    r_an;
  logic [6:0]    r_seg, w_digitSeg;

  function automatic logic [6:0] hundredsSeg(input logic [11:0] v);
    return (v[11:8] == 4'd0) ? SEG_BLANK : seg_encode(v[11:8]);
  endfunction

  function automatic logic [6:0] tensSeg(input logic [11:0] v);
    return (v[11:8] == 4'd0 && v[7:4] == 4'd0) ? SEG_BLANK : seg_encode(v[7:4]);
  endfunction

  assign w_change = ({P1score, P2score} != r_lastSrc);

  // P1 starts one cycle after capture so it converts the registered snapshot; P2 is
  // started the cycle P1's done is seen, keeping the whole update at 20 cycles.
  assign w_cvtStart = r_startP1 | (r_state == CONV_P1 && w_cvtDone);
  assign w_cvtBin   = r_startP1 ? r_snap[15:8] : r_snap[7:0];

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (w_cvtStart),
    .bin   (w_cvtBin),
    .done  (w_cvtDone),
    .bcd   (w_cvtBcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_change) w_nextState = CONV_P1;
      CONV_P1: if (w_cvtDone) w_nextState = CONV_P2;
      CONV_P2: if (w_cvtDone) w_nextState = COMMIT;
      COMMIT:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Display registers only move in COMMIT, so both scores update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lastSrc <= '0;
      r_snap    <= '0;
      r_startP1 <= 1'b0;
      r_stageP1 <= '0;
      r_stageP2 <= '0;
      r_dispP1  <= '0;
      r_dispP2  <= '0;
    end else begin
      r_startP1 <= (r_state == IDLE) && w_change;
      if (r_state == IDLE && w_change) r_snap <= {P1score, P2score};
      if (r_state == CONV_P1 && w_cvtDone) r_stageP1 <= w_cvtBcd;
      if (r_state == CONV_P2 && w_cvtDone) r_stageP2 <= w_cvtBcd;
      if (r_state == COMMIT) begin
        r_dispP1  <= r_stageP1;
        r_dispP2  <= r_stageP2;
        r_lastSrc <= r_snap;
      end
    end
  end

  always_comb begin
    w_digitSeg = SEG_BLANK;
    case (r_digitIdx)
      3'd0:    w_digitSeg = seg_encode(r_dispP2[3:0]);
      3'd1:    w_digitSeg = tensSeg(r_dispP2);
      3'd2:    w_digitSeg = hundredsSeg(r_dispP2);
      3'd4:    w_digitSeg = seg_encode(r_dispP1[3:0]);
      3'd5:    w_digitSeg = tensSeg(r_dispP1);
      3'd6:    w_digitSeg = hundredsSeg(r_dispP1);
      default: w_digitSeg = SEG_BLANK;
    endcase
  end

  // Anode and segment registers lag the digit index by one cycle, always together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refresh  <= '0;
      r_digitIdx <= '0;
      r_an       <= 8'hFF;
      r_seg      <= SEG_BLANK;
    end else begin
      if (r_refresh == REFRESH_LAST) begin
        r_refresh  <= '0;
        r_digitIdx <= r_digitIdx + 3'd1;
      end else begin
        r_refresh <= r_refresh + CW'(1);
      end
      r_an  <= ~(8'd1 << r_digitIdx);
      r_seg <= w_digitSeg;
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign dp   = 1'b1;
  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_score_display.sv
// Directed bench for score_display: table of score pairs with hand-computed digit
// segments, plus sequences for mid-conversion changes, scan order and async reset.
module tb_score_display;

  localparam int DIGIT_CYCLES = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] P1score = 8'd0;
  logic [7:0] P2score = 8'd0;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int vectorCount = 0;
  int missCount = 0;

  // expSeg packs per-digit segments, index 0 = rightmost digit.
  typedef struct packed {
    logic [7:0]      p1;
    logic [7:0]      p2;
    logic [7:0][6:0] expSeg;
  } vec_t;

  vec_t vecs[6];

  score_display #(.DIGIT_CYCLES(DIGIT_CYCLES)) dut (
    .clk     (clk),
    .reset   (reset),
    .P1score (P1score),
    .P2score (P2score),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] p1, input logic [7:0] p2);
    @(negedge clk);
    P1score = p1;
    P2score = p2;
  endtask

  // Counts consecutive negedge samples with busy at 'level'; consumes the first other sample.
  task automatic measureBusy(input logic level, output int cycles);
    cycles = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (busy === level) cycles++;
      else break;
    end
  endtask

  task automatic readDigit(input int idx, output logic [6:0] s);
    logic [7:0] target;
    bit found;
    target = ~(8'd1 << idx);
    found = 1'b0;
    s = 7'hxx;
    for (int n = 0; n < 80 && !found; n++) begin
      @(negedge clk);
      if (an === target) begin
        found = 1'b1;
        s = seg;
      end
    end
  endtask

  task automatic checkDigits(input string tag, input logic [7:0][6:0] expSeg);
    logic [6:0] s;
    for (int i = 0; i < 8; i++) begin
      readDigit(i, s);
      checkOutput($sformatf("%s seg idx%0d", tag, i), {1'b0, s}, {1'b0, expSeg[i]});
    end
  endtask

  task automatic runVector(input vec_t v, input string tag, input bit expectConv);
    int cycles;
    applyStimulus(v.p1, v.p2);
    if (expectConv) begin
      measureBusy(1'b1, cycles);
      checkOutput({tag, " busy cycles"}, 8'(cycles), 8'd20);
    end else begin
      cycles = 0;
      for (int n = 0; n < 30; n++) begin
        @(negedge clk);
        if (busy !== 1'b0) cycles++;
      end
      checkOutput({tag, " busy idle"}, 8'(cycles), 8'd0);
    end
    @(negedge clk);
    checkDigits(tag, v.expSeg);
  endtask

  initial begin
    int cycles, idle;
    int idx;
    logic [7:0] oneHot;
    logic [7:0][6:0] mid;
    logic [7:0][6:0] fin;

    vecs[0] = '{8'd0,   8'd0,   {7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[1] = '{8'd255, 8'd7,   {7'h7F, 7'h24, 7'h12, 7'h12, 7'h7F, 7'h7F, 7'h7F, 7'h78}};
    vecs[2] = '{8'd105, 8'd10,  {7'h7F, 7'h79, 7'h40, 7'h12, 7'h7F, 7'h7F, 7'h79, 7'h40}};
    vecs[3] = '{8'd9,   8'd100, {7'h7F, 7'h7F, 7'h7F, 7'h10, 7'h7F, 7'h79, 7'h40, 7'h40}};
    vecs[4] = '{8'd38,  8'd250, {7'h7F, 7'h7F, 7'h30, 7'h00, 7'h7F, 7'h24, 7'h12, 7'h40}};
    vecs[5] = '{8'd64,  8'd199, {7'h7F, 7'h7F, 7'h02, 7'h19, 7'h7F, 7'h79, 7'h10, 7'h10}};
    mid     = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h30};
    fin     = {7'h7F, 7'h7F, 7'h79, 7'h24, 7'h7F, 7'h7F, 7'h7F, 7'h19};

    // Reset held for 5 cycles with zero scores.
    repeat (5) @(negedge clk);
    checkOutput("reset an", an, 8'hFF);
    checkOutput("reset seg", {1'b0, seg}, 8'h7F);
    checkOutput("reset busy", {7'd0, busy}, 8'd0);
    checkOutput("reset dp", {7'd0, dp}, 8'd1);
    reset = 1'b1;

    runVector(vecs[0], "v0", 1'b0);
    for (int v = 1; v < 6; v++) begin
      runVector(vecs[v], $sformatf("v%0d", v), 1'b1);
    end

    // P2 changes while P2 is converting: the snapshot commits, then a reconversion follows.
    applyStimulus(8'd12, 8'd3);
    cycles = 0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (busy === 1'b1) cycles++;
    end
    P2score = 8'd4;
    measureBusy(1'b1, idle);
    checkOutput("midchange first busy", 8'(cycles + idle), 8'd20);
    measureBusy(1'b0, idle);
    checkOutput("midchange idle gap", 8'(idle + 1), 8'd1);
    cycles = 1;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (busy === 1'b1) cycles++;
      idx = -1;
      for (int i = 0; i < 8; i++) begin
        oneHot = ~(8'd1 << i);
        if (an === oneHot) idx = i;
      end
      checkOutput("midchange an onehot", {7'd0, idx >= 0}, 8'd1);
      if (idx >= 0) checkOutput($sformatf("midchange snapshot idx%0d", idx), {1'b0, seg}, {1'b0, mid[idx]});
    end
    measureBusy(1'b1, idle);
    checkOutput("midchange second busy", 8'(cycles + idle), 8'd20);
    @(negedge clk);
    checkDigits("midchange final", fin);

    // Free-running scan order, 4 cycles per digit, wrapping back to the first digit.
    idle = 0;
    for (int n = 0; n < 80 && idle == 0; n++) begin
      @(negedge clk);
      if (an === 8'h7F) idle = 1;
    end
    for (int n = 0; n < 10 && an !== 8'hFE; n++) @(negedge clk);
    for (int j = 0; j < 33; j++) begin
      if (j > 0) @(negedge clk);
      oneHot = ~(8'd1 << ((j / 4) % 8));
      checkOutput($sformatf("scan an step%0d", j), an, oneHot);
    end

    // Async reset asserted between edges while P1 is converting.
    applyStimulus(8'd77, 8'd33);
    repeat (3) @(negedge clk);
    checkOutput("pre-reset busy", {7'd0, busy}, 8'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset an", an, 8'hFF);
    checkOutput("async reset seg", {1'b0, seg}, 8'h7F);
    checkOutput("async reset busy", {7'd0, busy}, 8'd0);
    checkOutput("async reset dp", {7'd0, dp}, 8'd1);
    P1score = 8'd0;
    P2score = 8'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    runVector(vecs[0], "post-reset", 1'b0);
    checkOutput("final dp", {7'd0, dp}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
